fdiv_seq_ctrl: RTL and testbench
================================

Name: fdiv_seq_ctrl

Overview:
Sequencing and result-finishing stage wrapped around the single-precision combinational divider in the RV32IMF FPU.
- Accepts an FDIV.S request from the FP issue logic over a valid/ready handshake.
- Registers the operands that drive the divider's N1/N2 inputs and waits a fixed settle time before sampling the divider result.
- Resolves IEEE special cases and exponent over/underflow, which the divider does not handle.
- Returns the result, destination register and RISC-V fflags to FP writeback over a second valid/ready handshake.

Parameters:
- DIV_LAT, default 2: cycles the operand registers are held stable before div_result is sampled; legal range 1..15.
- CANON_NAN, default 32'h7FC00000: canonical quiet NaN returned for every NaN result.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  pipeline kill; aborts any in-flight op
- req_valid  in  1  request valid
- req_ready  out  1  block can accept a request
- req_a  in  32  dividend, IEEE-754 single
- req_b  in  32  divisor, IEEE-754 single
- req_rd  in  5  destination register tag
- div_n1  out  32  registered dividend to divider N1
- div_n2  out  32  registered divisor to divider N2
- div_result  in  32  divider result (combinational from div_n1/div_n2)
- resp_valid  out  1  response valid
- resp_ready  in  1  writeback accepts response
- resp_data  out  32  final quotient
- resp_rd  out  5  destination tag of response
- resp_flags  out  5  fflags {NV,DZ,OF,UF,NX}, bit4..bit0
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (rst_n==0 at a clk edge): state=IDLE; req_ready=1, resp_valid=0, busy=0; resp_data, resp_flags, resp_rd, div_n1, div_n2 and the counter all 0. Reset mid-operation drops the op with no response.
- Flush has priority over all other events except reset: state=IDLE, resp_valid=0, pending result discarded, counter cleared. A request presented in the flush cycle is not accepted.
- req_ready = (state==IDLE). Accept occurs when req_valid && req_ready at an edge. The accept edge loads div_n1=req_a, div_n2=req_b, the rd tag, and the classification.
- Operand classification (exponent field e, fraction f):
  - e==0: zero. Denormals are flushed to signed zero.
  - e==FF, f==0: infinity.
  - e==FF, f!=0: NaN; signalling NaN if f[22]==0.
- Special-case table, evaluated in this priority order. Sign s = a[31]^b[31].
  1. Either operand NaN: CANON_NAN; NV if either is sNaN.
  2. inf/inf or 0/0: CANON_NAN, NV.
  3. Finite nonzero / 0: {s,8'hFF,23'b0}, DZ.
  4. inf / finite: {s,FF,0}, no flags.
  5. finite / inf, or 0 / finite nonzero: {s,31'b0}, no flags.
- Exponent pre-check for normal/normal operands: ediff = ea - eb + 127, 10-bit signed.
  - ediff >= 255: overflow → {s,FF,0}, flags OF|NX.
  - ediff <= 0: underflow → {s,31'b0}, flags UF|NX.
  - Both checks are treated as special cases.
- FSM states:
  - IDLE: accepted special case → DONE with result latched at the accept edge. Accepted normal op → WAIT with counter=DIV_LAT-1.
  - WAIT: counter decrements each cycle. When counter==0, sample div_result and go to DONE.
  - DONE: resp_valid=1; resp_data, resp_rd and resp_flags held stable until resp_valid && resp_ready, then go to IDLE.
- Post-check on sampled div_result (normal path):
  - Exponent field 8'hFF: force {s,FF,0}, flags OF|NX.
  - Exponent field 0: force {s,31'b0}, flags UF|NX.
  - Otherwise pass through, flags 0. NX is not reported for the divider's truncation.
- Latency, counted from the accept edge:
  - Special case: resp_valid rises after 1 edge.
  - Normal path: resp_valid rises after DIV_LAT+1 edges.
  - Throughput: a new accept is possible no earlier than the cycle after the response handshake.
- div_n1/div_n2 change only on accept; they stay stable through WAIT and DONE.
- resp_ready asserted while not in DONE has no effect.

Test Plan:
- 6.0/2.0 (a=0x40C00000, b=0x40000000), resp_ready=1, DIV_LAT=2 → resp_data=0x40400000, flags=0, resp_valid exactly 3 edges after accept, busy high throughout.
- 1.0/+0 (0x3F800000/0x00000000) → 0x7F800000, flags=0x08 (DZ), 1-cycle latency. Repeat with -1.0 → 0xFF800000.
- 0/0 → 0x7FC00000, flags=0x10. sNaN 0x7F800001 / 1.0 → 0x7FC00000, flags=0x10. qNaN 0x7FC00001 / 1.0 → 0x7FC00000, flags=0.
- Exponent limits:
  - 0x7F000000 / 0x00800000 → 0x7F800000, flags=0x05.
  - 0x00800000 / 0x7F000000 → 0x00000000, flags=0x03.
- Backpressure: hold resp_ready=0 for 5 cycles → resp_valid, resp_data and resp_rd stay stable and req_ready stays 0; then resp_ready=1 → IDLE next edge, and a back-to-back second request is accepted the following cycle.
- Flush or reset mid-operation:
  - Assert flush in WAIT → no response, IDLE next edge, next request completes normally.
  - Drive rst_n=0 in DONE → all outputs at reset values.

Source files
------------

// File: rtl/fdiv_seq_ctrl.sv
// Sequencing and result-finishing wrapper around the combinational FP32 divider.
// Handles IEEE special cases and exponent range, returning quotient, rd tag and fflags.
module fdiv_seq_ctrl #(
    parameter int          DIV_LAT   = 2,
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    output logic [31:0] div_n1,
    output logic [31:0] div_n2,
    input  logic [31:0] div_result,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic [4:0]  resp_flags,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(DIV_LAT - 1);
    localparam logic [4:0] FL_NV = 5'b10000;
    localparam logic [4:0] FL_DZ = 5'b01000;
    localparam logic [4:0] FL_OF = 5'b00100;
    localparam logic [4:0] FL_UF = 5'b00010;
    localparam logic [4:0] FL_NX = 5'b00001;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q;
    logic        sign_q;

    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_zero, a_inf, a_nan, a_snan;
    logic        b_zero, b_inf, b_nan, b_snan;
    logic        req_sign;
    logic signed [9:0] ediff;

    logic        spec_hit;
    logic [31:0] spec_data;
    logic [4:0]  spec_flags;
    logic [31:0] post_data;
    logic [4:0]  post_flags;

    assign ea       = req_a[30:23];
    assign eb       = req_b[30:23];
    assign fa       = req_a[22:0];
    assign fb       = req_b[22:0];
    assign req_sign = req_a[31] ^ req_b[31];

    // Denormals have e==0 and are deliberately treated as signed zero.
    assign a_zero = (ea == 8'h00);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign a_snan = a_nan && !fa[22];
    assign b_zero = (eb == 8'h00);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    assign b_snan = b_nan && !fb[22];

    assign ediff = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        spec_hit   = 1'b1;
        spec_data  = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_data  = CANON_NAN;
            spec_flags = (a_snan || b_snan) ? FL_NV : 5'd0;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            spec_data  = CANON_NAN;
            spec_flags = FL_NV;
        end else if (b_zero && !a_inf) begin
            spec_data  = {req_sign, 8'hFF, 23'd0};
            spec_flags = FL_DZ;
        end else if (a_inf) begin
            spec_data  = {req_sign, 8'hFF, 23'd0};
        end else if (b_inf || a_zero) begin
            spec_data  = {req_sign, 31'd0};
        end else if (ediff >= 10'sd255) begin
            spec_data  = {req_sign, 8'hFF, 23'd0};
            spec_flags = FL_OF | FL_NX;
        end else if (ediff <= 10'sd0) begin
            spec_data  = {req_sign, 31'd0};
            spec_flags = FL_UF | FL_NX;
        end else begin
            spec_hit   = 1'b0;
        end
    end

    // The divider itself does not saturate, so clamp its exponent extremes here.
    always_comb begin
        post_data  = div_result;
        post_flags = '0;
        if (div_result[30:23] == 8'hFF) begin
            post_data  = {sign_q, 8'hFF, 23'd0};
            post_flags = FL_OF | FL_NX;
        end else if (div_result[30:23] == 8'h00) begin
            post_data  = {sign_q, 31'd0};
            post_flags = FL_UF | FL_NX;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = spec_hit ? S_DONE : S_WAIT;
            S_WAIT:  if (cnt_q == 4'd0) state_d = S_DONE;
            S_DONE:  if (resp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            div_n1     <= '0;
            div_n2     <= '0;
            resp_data  <= '0;
            resp_rd    <= '0;
            resp_flags <= '0;
        end else if (flush) begin
            cnt_q      <= '0;
            resp_data  <= '0;
            resp_flags <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        div_n1  <= req_a;
                        div_n2  <= req_b;
                        resp_rd <= req_rd;
                        sign_q  <= req_sign;
                        if (spec_hit) begin
                            resp_data  <= spec_data;
                            resp_flags <= spec_flags;
                        end else begin
                            cnt_q <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        resp_data  <= post_data;
                        resp_flags <= post_flags;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fdiv_seq_ctrl.sv
// Scoreboard bench for fdiv_seq_ctrl: directed FDIV.S vectors with hand-computed results.
// A stand-in divider answers a fixed table of operand pairs.
module tb_fdiv_seq_ctrl;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [4:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, req_valid, req_ready, resp_valid, resp_ready, busy;
    logic [31:0] req_a, req_b, div_n1, div_n2, div_result, resp_data;
    logic [4:0]  req_rd, resp_rd, resp_flags;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fdiv_seq_ctrl #(.DIV_LAT(2), .CANON_NAN(32'h7FC00000)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .div_n1(div_n1), .div_n2(div_n2), .div_result(div_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_rd(resp_rd), .resp_flags(resp_flags),
        .busy(busy)
    );

    // Stand-in divider; the last two entries return out-of-range exponents on purpose.
    always_comb begin
        div_result = 32'hDEADBEEF;
        case ({div_n1, div_n2})
            {32'h40C00000, 32'h40000000}: div_result = 32'h40400000;
            {32'h3F800000, 32'h40800000}: div_result = 32'h3E800000;
            {32'h41200000, 32'h3F000000}: div_result = 32'h41A00000;
            {32'h3F800001, 32'h3F800000}: div_result = 32'h7F812345;
            {32'hBF800001, 32'h3F800000}: div_result = 32'h00012345;
            default: ;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a response is consumed at the edge following a negedge where valid&&ready.
    always @(negedge clk) begin
        if (rst_n && !flush && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp: got data %h with no expected entry", resp_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_data", resp_data, e.data);
                check("resp_rd", 32'(resp_rd), 32'(e.rd));
                check("resp_flags", 32'(resp_flags), 32'(e.flags));
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] ed, input logic [4:0] ef, input bit expect_resp);
        if (expect_resp) sb.push_back('{data: ed, rd: rd, flags: ef});
        req_a = a; req_b = b; req_rd = rd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("div_n1", div_n1, a);
        check("div_n2", div_n2, b);
    endtask

    task automatic wait_valid(input int elat);
        int lat = 1;
        bit busy_ok = 1'b1;
        while (!resp_valid && lat < 64) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(elat));
        check("busy_during_op", 32'(busy_ok), 32'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] ed, input logic [4:0] ef, input int elat);
        send(a, b, rd, ed, ef, 1'b1);
        wait_valid(elat);
        @(posedge clk); #1;
        check("idle_after_handshake", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        req_a = '0; req_b = '0; req_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_div_n1", div_n1, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'h40C00000, 32'h40000000, 5'd1,  32'h40400000, 5'h00, 3);  // 6/2
        run_op(32'h3F800000, 32'h00000000, 5'd2,  32'h7F800000, 5'h08, 1);  // 1/+0
        run_op(32'hBF800000, 32'h00000000, 5'd3,  32'hFF800000, 5'h08, 1);  // -1/+0
        run_op(32'h00000000, 32'h00000000, 5'd4,  32'h7FC00000, 5'h10, 1);  // 0/0
        run_op(32'h7F800001, 32'h3F800000, 5'd5,  32'h7FC00000, 5'h10, 1);  // sNaN
        run_op(32'h7FC00001, 32'h3F800000, 5'd6,  32'h7FC00000, 5'h00, 1);  // qNaN
        run_op(32'h7F000000, 32'h00800000, 5'd7,  32'h7F800000, 5'h05, 1);  // pre-check OF
        run_op(32'h00800000, 32'h7F000000, 5'd8,  32'h00000000, 5'h03, 1);  // pre-check UF
        run_op(32'h3F800000, 32'h40800000, 5'd9,  32'h3E800000, 5'h00, 3);  // 1/4
        run_op(32'h7F800000, 32'h40000000, 5'd10, 32'h7F800000, 5'h00, 1);  // inf/2
        run_op(32'h40000000, 32'hFF800000, 5'd11, 32'h80000000, 5'h00, 1);  // 2/-inf
        run_op(32'h7F800000, 32'h7F800000, 5'd12, 32'h7FC00000, 5'h10, 1);  // inf/inf
        run_op(32'h7F800000, 32'h00000000, 5'd13, 32'h7F800000, 5'h00, 1);  // inf/0
        run_op(32'h00000001, 32'h3F800000, 5'd14, 32'h00000000, 5'h00, 1);  // denormal/1
        run_op(32'h3F800001, 32'h3F800000, 5'd15, 32'h7F800000, 5'h05, 3);  // post-check OF
        run_op(32'hBF800001, 32'h3F800000, 5'd16, 32'h80000000, 5'h03, 3);  // post-check UF

        // Backpressure, then back-to-back request right after the handshake.
        resp_ready = 1'b0;
        send(32'h41200000, 32'h3F000000, 5'd20, 32'h41A00000, 5'h00, 1'b1);
        wait_valid(3);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_resp_data", resp_data, 32'h41A00000);
            check("bp_resp_rd", 32'(resp_rd), 32'd20);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_idle", 32'(req_ready), 32'd1);
        check("bp_release_valid", 32'(resp_valid), 32'd0);
        send(32'h40C00000, 32'h40000000, 5'd21, 32'h40400000, 5'h00, 1'b1);
        wait_valid(3);
        @(posedge clk); #1;

        // Flush while waiting on the divider.
        send(32'h40C00000, 32'h40000000, 5'd22, 32'h0, 5'h0, 1'b0);
        check("flush_pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_idle", 32'(req_ready), 32'd1);
        check("flush_no_valid", 32'(resp_valid), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("flush_still_no_valid", 32'(resp_valid), 32'd0);
        run_op(32'h3F800000, 32'h40800000, 5'd23, 32'h3E800000, 5'h00, 3);

        // Reset while a response is pending in DONE.
        resp_ready = 1'b0;
        send(32'h3F800000, 32'h00000000, 5'd24, 32'h0, 5'h0, 1'b0);
        wait_valid(1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstd_req_ready", 32'(req_ready), 32'd1);
        check("rstd_resp_valid", 32'(resp_valid), 32'd0);
        check("rstd_busy", 32'(busy), 32'd0);
        check("rstd_resp_data", resp_data, 32'd0);
        check("rstd_resp_flags", 32'(resp_flags), 32'd0);
        check("rstd_resp_rd", 32'(resp_rd), 32'd0);
        check("rstd_div_n1", div_n1, 32'd0);
        check("rstd_div_n2", div_n2, 32'd0);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        run_op(32'h40C00000, 32'h40000000, 5'd25, 32'h40400000, 5'h00, 3);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
